// File: rtl/thread_out_pkg.sv
// Shared types and default widths for the per-thread output buffer.
package thread_out_pkg;

    localparam int DATAPATH_WIDTH_DEF = 64;
    localparam int CTRL_WIDTH_DEF     = 8;
    localparam int ADDR_BITS_DEF      = 9;
    localparam int WORD_W_DEF         = DATAPATH_WIDTH_DEF + CTRL_WIDTH_DEF;

    typedef enum logic [1:0] {
        ST_LOAD      = 2'd0,
        ST_HOLD      = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/outbuf_ram.sv
// Simple dual-port packet store: one write port, one registered read port.
module outbuf_ram #(
    parameter int ADDR_BITS = 9,
    parameter int WIDTH     = 72
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [WIDTH-1:0]     rd_data_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // No reset on the array or read register so the store maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/thread_out_buffer.sv
// Per-thread output buffer: stores one packet from the thread, then streams it
// to the output arbiter on command and frees itself on the arbiter's acknowledge.
module thread_out_buffer
    import thread_out_pkg::*;
#(
    parameter int DATAPATH_WIDTH = DATAPATH_WIDTH_DEF,
    parameter int CTRL_WIDTH     = CTRL_WIDTH_DEF,
    parameter int ADDR_BITS      = ADDR_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATAPATH_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0]     in_ctrl,
    input  logic                      in_wr,
    input  logic                      in_eop,
    output logic                      in_rdy,
    output logic                      thread_done,
    input  logic                      start_read,
    input  logic                      read_done,
    input  logic                      out_rdy,
    output logic [DATAPATH_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0]     out_ctrl,
    output logic                      out_wr,
    output logic                      out_wr_early,
    output logic                      err_trunc,
    output state_e                    dbg_state
);

    // Handshakes: a thread word transfers on any cycle with in_wr && in_rdy;
    // a read issues on any DRAIN cycle with out_rdy, flagged by out_wr_early,
    // and the word appears with out_wr exactly one cycle later.
    localparam int WORD_W = DATAPATH_WIDTH + CTRL_WIDTH;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS-1:0] last_q, last_d;
    logic                 thread_done_q, thread_done_d;
    logic                 err_trunc_q, err_trunc_d;
    logic                 out_wr_q;
    logic                 wr_en, rd_en, at_last_slot;
    logic [WORD_W-1:0]    rd_word;

    assign wr_en        = (state_q == ST_LOAD) && in_wr;
    assign rd_en        = (state_q == ST_DRAIN) && out_rdy;
    assign at_last_slot = &wr_ptr_q;

    outbuf_ram #(
        .ADDR_BITS (ADDR_BITS),
        .WIDTH     (WORD_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({in_ctrl, in_data}),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            last_q        <= '0;
            thread_done_q <= 1'b0;
            err_trunc_q   <= 1'b0;
            out_wr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            last_q        <= last_d;
            thread_done_q <= thread_done_d;
            err_trunc_q   <= err_trunc_d;
            out_wr_q      <= rd_en;
        end
    end

    // last_q holds len-1, so a full DEPTH-word packet fits in ADDR_BITS.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        last_d        = last_q;
        thread_done_d = 1'b0;
        err_trunc_d   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_wr) begin
                    wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
                    if (in_eop || at_last_slot) begin
                        last_d        = wr_ptr_q;
                        thread_done_d = 1'b1;
                        err_trunc_d   = !in_eop;
                        state_d       = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (start_read) begin
                    rd_ptr_d = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_rdy) begin
                    rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
                    if (rd_ptr_q == last_q) begin
                        state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (read_done) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    state_d  = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        in_rdy       = (state_q == ST_LOAD);
        thread_done  = thread_done_q;
        err_trunc    = err_trunc_q;
        out_wr       = out_wr_q;
        out_wr_early = rd_en;
        out_data     = out_wr_q ? rd_word[DATAPATH_WIDTH-1:0] : '0;
        out_ctrl     = out_wr_q ? rd_word[WORD_W-1:DATAPATH_WIDTH] : '0;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_thread_out_buffer.sv
// Bench for thread_out_buffer: drives packets in, streams them out and
// scores every streamed word against the words it pushed.
module tb_thread_out_buffer;
    import thread_out_pkg::*;

    localparam int DW     = 64;
    localparam int CW     = 8;
    localparam int AB     = 9;
    localparam int DEPTH  = 1 << AB;
    localparam int WORD_W = DW + CW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_wr, in_eop, in_rdy, thread_done;
    logic          start_read, read_done, out_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr, out_wr_early, err_trunc;
    state_e        dut_state;

    logic [WORD_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_miss = 0;
    int early_cnt = 0;
    int wr_cnt = 0;
    bit mon_en = 1'b0;
    bit prev_early = 1'b0;

    thread_out_buffer #(
        .DATAPATH_WIDTH (DW),
        .CTRL_WIDTH     (CW),
        .ADDR_BITS      (AB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .in_wr        (in_wr),
        .in_eop       (in_eop),
        .in_rdy       (in_rdy),
        .thread_done  (thread_done),
        .start_read   (start_read),
        .read_done    (read_done),
        .out_rdy      (out_rdy),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .out_wr       (out_wr),
        .out_wr_early (out_wr_early),
        .err_trunc    (err_trunc),
        .dbg_state    (dut_state)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: out_wr must trail out_wr_early by one cycle; every word is scored.
    always @(negedge clk) begin
        if (mon_en) begin
            check_vec("wr_after_early", out_wr, prev_early);
            if (out_wr) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check_vec("spurious_wr", out_wr, 1'b0);
                end else begin
                    check_vec("out_word", {out_ctrl, out_data}, exp_q.pop_front());
                end
            end
            if (out_wr_early) early_cnt++;
            prev_early = out_wr_early && !reset;
        end
    end

    task automatic send_pkt(input int n, input logic [DW-1:0] base, input logic [CW-1:0] ctrl0);
        int eff_last = (n > DEPTH) ? DEPTH - 1 : n - 1;
        bit trunc = (n > DEPTH);
        check_vec("in_rdy_start", in_rdy, 1'b1);
        for (int i = 0; i < n; i++) begin
            in_wr   = 1'b1;
            in_eop  = (i == n - 1);
            in_ctrl = (i == 0) ? ctrl0 : '0;
            in_data = (n > 16) ? {$urandom(), $urandom()} : base + DW'(i);
            if (i <= eff_last) exp_q.push_back({in_ctrl, in_data});
            @(posedge clk); #1;
            check_vec("thread_done", thread_done, i == eff_last);
            check_vec("err_trunc", err_trunc, (i == eff_last) && trunc);
            check_vec("in_rdy_load", in_rdy, i < eff_last);
        end
        in_wr  = 1'b0;
        in_eop = 1'b0;
        @(posedge clk); #1;
        check_vec("thread_done_end", thread_done, 1'b0);
        check_vec("err_trunc_end", err_trunc, 1'b0);
    endtask

    task automatic drain(input int n, input int gap_at, input int gap_len,
                         input bit rd_on_last, input bit both);
        int e0 = early_cnt;
        int w0 = wr_cnt;
        int issued = 0;
        int stall = 0;
        int cyc = 0;
        bit rd_sent = 1'b0;
        start_read = 1'b1;
        read_done  = both;
        @(posedge clk); #1;
        start_read = 1'b0;
        read_done  = 1'b0;
        check_vec("state_drain", dut_state, ST_DRAIN);
        while ((issued < n || exp_q.size() > 0) && cyc < 3000) begin
            if (issued == gap_at && stall < gap_len) begin
                out_rdy = 1'b0;
                stall++;
            end else begin
                out_rdy = 1'b1;
            end
            if (rd_on_last && issued == n && !rd_sent) begin
                read_done = 1'b1;
                rd_sent   = 1'b1;
            end
            if (out_rdy && issued < n) issued++;
            @(posedge clk); #1;
            read_done = 1'b0;
            cyc++;
        end
        check_vec("drain_bound", cyc < 3000, 1'b1);
        check_vec("queue_empty", exp_q.size(), 0);
        if (!rd_sent) begin
            check_vec("state_wait", dut_state, ST_WAIT_DONE);
            read_done = 1'b1;
            @(posedge clk); #1;
            read_done = 1'b0;
        end
        out_rdy = 1'b1;
        check_vec("in_rdy_after_done", in_rdy, 1'b1);
        check_vec("state_load", dut_state, ST_LOAD);
        check_vec("early_count", early_cnt - e0, n);
        check_vec("wr_count", wr_cnt - w0, n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_data = '0; in_ctrl = '0; in_wr = 1'b0; in_eop = 1'b0;
        start_read = 1'b0; read_done = 1'b0; out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_vec("rst_in_rdy", in_rdy, 1'b1);
        check_vec("rst_thread_done", thread_done, 1'b0);
        check_vec("rst_out_wr", out_wr, 1'b0);
        check_vec("rst_out_wr_early", out_wr_early, 1'b0);
        check_vec("rst_err_trunc", err_trunc, 1'b0);
        check_vec("rst_out_word", {out_ctrl, out_data}, '0);
        check_vec("rst_state", dut_state, ST_LOAD);
        mon_en = 1'b1;

        // start_read outside HOLD is ignored
        start_read = 1'b1;
        @(posedge clk); #1;
        start_read = 1'b0;
        check_vec("ign_start_state", dut_state, ST_LOAD);
        check_vec("ign_start_rdy", in_rdy, 1'b1);

        // 4-word packet; read_done in HOLD is ignored
        send_pkt(4, 64'h1, 8'hFF);
        read_done = 1'b1;
        @(posedge clk); #1;
        read_done = 1'b0;
        check_vec("ign_done_state", dut_state, ST_HOLD);
        check_vec("ign_done_out_wr", out_wr, 1'b0);
        drain(4, -1, 0, 1'b0, 1'b0);

        // same packet with a 3-cycle out_rdy stall after word 2
        send_pkt(4, 64'h1, 8'hFF);
        drain(4, 2, 3, 1'b0, 1'b0);

        // single-word packet
        send_pkt(1, 64'hAB, 8'h01);
        drain(1, -1, 0, 1'b0, 1'b0);

        // 513 words without eop: truncated at DEPTH
        send_pkt(DEPTH + 1, '0, 8'hC3);
        drain(DEPTH, 100, 2, 1'b0, 1'b0);

        // back-to-back packets, read_done on the final out_wr cycle
        send_pkt(2, 64'h100, 8'hA5);
        drain(2, -1, 0, 1'b1, 1'b0);
        send_pkt(3, 64'h200, 8'h5A);
        drain(3, -1, 0, 1'b1, 1'b0);

        // start_read and read_done together in HOLD: start_read wins
        send_pkt(4, 64'h300 + DW'($urandom_range(0, 255)), 8'h77);
        drain(4, 1, $urandom_range(1, 4), 1'b0, 1'b1);

        // reset in the middle of draining a 10-word packet
        send_pkt(10, 64'h400, 8'h11);
        start_read = 1'b1;
        @(posedge clk); #1;
        start_read = 1'b0;
        out_rdy = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check_vec("mid_rst_out_wr", out_wr, 1'b0);
        check_vec("mid_rst_in_rdy", in_rdy, 1'b1);
        check_vec("mid_rst_early", out_wr_early, 1'b0);
        check_vec("mid_rst_state", dut_state, ST_LOAD);
        check_vec("mid_rst_word", {out_ctrl, out_data}, '0);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;

        // recovery after reset
        send_pkt(2, 64'h500, 8'h22);
        drain(2, -1, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/thread_out_buffer.md
Name: thread_out_buffer

Overview:
- Per-thread packet output buffer between a processing thread's output port and the round-robin output-FIFO arbiter; one instance per thread.
- Accepts one complete packet from the thread, then signals completion with a `thread_done` pulse.
- Streams the packet on arbiter command, one word per cycle when downstream is ready, with a one-cycle-early write indication.
- Frees itself on the arbiter's `read_done` acknowledge.

Parameters:
- DATAPATH_WIDTH, 64, data word width
- CTRL_WIDTH, 8, control word width
- ADDR_BITS, 9, log2 of buffer depth; DEPTH = 2^ADDR_BITS words (512)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATAPATH_WIDTH  thread output data word
- in_ctrl  in  CTRL_WIDTH  thread output ctrl word
- in_wr  in  1  word valid from thread
- in_eop  in  1  qualifies in_wr: this word is the last of the packet
- in_rdy  out  1  buffer accepting words
- thread_done  out  1  one-cycle pulse: packet fully stored
- start_read  in  1  arbiter command: begin streaming (pulse)
- read_done  in  1  arbiter acknowledge: packet consumed, free buffer (pulse)
- out_rdy  in  1  downstream output queue ready
- out_data  out  DATAPATH_WIDTH  streamed data word
- out_ctrl  out  CTRL_WIDTH  streamed ctrl word
- out_wr  out  1  streamed word valid
- out_wr_early  out  1  high exactly one cycle before each out_wr cycle
- err_trunc  out  1  one-cycle pulse: packet truncated at DEPTH words

Behaviour:
- Reset values:
  - State LOAD; wr_ptr = rd_ptr = 0.
  - in_rdy = 1; thread_done = 0; out_wr = 0; out_wr_early = 0; err_trunc = 0.
  - out_data and out_ctrl = 0.
- States: LOAD, HOLD, DRAIN, WAIT_DONE.
- LOAD:
  - in_rdy = 1.
  - Each in_wr writes {in_ctrl, in_data} to RAM[wr_ptr] and increments wr_ptr.
  - in_wr && in_eop: store the word, latch len = wr_ptr+1, pulse thread_done next cycle, go to HOLD.
  - in_wr without eop at wr_ptr = DEPTH-1: the word is treated as eop. thread_done and err_trunc pulse together; go to HOLD.
  - Thread words after truncation are dropped (in_rdy = 0) until the next LOAD.
- HOLD:
  - in_rdy = 0; in_wr ignored.
  - start_read sampled high: go to DRAIN, rd_ptr = 0.
- DRAIN:
  - Each cycle with out_rdy = 1: issue RAM read of rd_ptr, drive out_wr_early = 1 (combinational from state and out_rdy), increment rd_ptr.
  - Registered RAM output presents out_data/out_ctrl with out_wr = 1 on the following cycle.
  - out_rdy = 0: no read issued, out_wr_early = 0, the pipeline bubble propagates (no duplicate words).
  - Issuing read at rd_ptr = len-1: go to WAIT_DONE. The last out_wr occurs in the first WAIT_DONE cycle; out_wr_early is 0 in that cycle.
- WAIT_DONE:
  - read_done sampled high: wr_ptr = rd_ptr = 0, go to LOAD; in_rdy = 1 the cycle after.
  - A read_done arriving in the same cycle as the final out_wr is legal.
- Commands outside their state are ignored, with no state change:
  - start_read outside HOLD.
  - read_done outside WAIT_DONE.
- Simultaneous start_read and read_done in HOLD: start_read wins.
- Single-word packet: len = 1; DRAIN lasts one out_rdy cycle; out_wr_early and out_wr are each a single cycle.
- Maximum packet: DEPTH words accepted with eop on the last word; err_trunc = 0.
- Reset mid-operation: immediate return to reset values; the stored packet is discarded; the RAM is not cleared.
- Throughput: 1 word/cycle in and out; buffer-to-output latency 1 cycle after out_wr_early.

Decomposition:
- Shared package (thread_out_pkg):
  - State encodings LOAD=0, HOLD=1, DRAIN=2, WAIT_DONE=3.
  - DATAPATH_WIDTH/CTRL_WIDTH defaults.
  - Word record width DATAPATH_WIDTH+CTRL_WIDTH.
- Sub-module outbuf_ram: simple dual-port, 1 write and 1 registered-read port, DEPTH × (DATAPATH_WIDTH+CTRL_WIDTH), block-RAM inferable.
- FSM, pointers, len and handshake logic live in the top module.

Test Plan:
- 4-word packet (ctrl FF,00,00,00; data 0x1..0x4), eop on word 4 -> thread_done one pulse 1 cycle after the eop cycle. Then start_read with out_rdy=1 -> out_wr_early high 4 cycles, out_wr high the next 4 cycles with data 0x1..0x4 in order.
- Same packet, out_rdy low for 3 cycles after word 2 issues -> out_wr gap of 3 cycles; words 3,4 follow unduplicated, in order.
- 1-word packet (ctrl 0x01, data 0xAB) -> thread_done pulse; out_wr_early and out_wr each exactly 1 cycle; in WAIT_DONE, read_done -> in_rdy = 1 next cycle.
- 513 words with no eop, DEPTH=512 -> err_trunc and thread_done on word 512; word 513 dropped; readout yields exactly 512 words.
- start_read pulse in LOAD and read_done pulse in HOLD -> no state change, no out_wr. Assert reset during DRAIN of a 10-word packet -> out_wr = 0 and in_rdy = 1 next cycle.
- Back-to-back packets of 2 and 3 words with read_done issued on the last out_wr cycle -> second packet stored and streamed correctly; no stale words from the first.
